ex_mem_reg: RTL and testbench
=============================

// Module: ex_mem_reg
// PURPOSE
//  EX->MEM pipeline register. Sits directly downstream of ds_ex_reg and consumes its
//  ex_to_mem_reg_valid / ds_ex_reg_data output once the EX combinational logic has run.
//  Holds the EX result and drives the data-memory request/response handshake.
//  Advances to mem_wb_reg only once any load/store has completed.
// PARAMETERS
//  EX_W    `EX_DATA  width of the EX result bundle carried to MEM
//  ADDR_W  32        data-memory address width
//  DATA_W  32        data-memory data width (strobe width = DATA_W/8)
// PORTS
//  clk                   in   1        clock
//  reset                 in   1        asynchronous, active-low reset
//  ex_to_mem_reg_valid   in   1        upstream (EX) holds a valid instruction
//  ex_mem_reg_allow_in   out  1        this stage can accept this cycle
//  ex_data               in   EX_W     EX result bundle
//  ex_mem_en             in   1        instruction accesses data memory
//  ex_mem_wr             in   1        1 = store, 0 = load
//  ex_mem_addr           in   ADDR_W   byte address
//  ex_mem_wdata          in   DATA_W   store data, pre-aligned
//  ex_mem_wstrb          in   DATA_W/8 byte enables for a store
//  mem_wb_reg_allow_in   in   1        downstream can accept
//  mem_to_wb_reg_valid   out  1        valid and ready_go toward mem_wb_reg
//  ex_mem_reg_data       out  EX_W     latched EX bundle
//  mem_rdata             out  DATA_W   load data: live bus data in the data_ok cycle, buffered copy afterwards
//  data_req              out  1        memory request
//  data_wr / data_addr / data_wdata / data_wstrb  out  request fields, held from latched copy
//  data_addr_ok          in   1        request accepted this cycle
//  data_data_ok          in   1        response (read data or write ack) this cycle
//  data_rdata            in   DATA_W   read data, valid with data_data_ok
// BEHAVIOUR
//  Reset (async, reset==0):
//   - valid=0, state=IDLE, data and all latched fields cleared to 0, rdata_buf=0.
//   - All request outputs are 0.
//   - The memory side is reset on the same reset, so any in-flight transaction is abandoned.
//  Handshake:
//   - allow_in = !valid || (ready_go && mem_wb_reg_allow_in).
//   - Capture on allow_in && ex_to_mem_reg_valid: latch ex_data and the mem_* fields, set valid=1.
//   - If allow_in && !ex_to_mem_reg_valid and downstream takes the entry: valid <= 0.
//   - mem_to_wb_reg_valid = valid && ready_go.
//  ready_go = !mem_en_q || (state==WAIT && data_data_ok) || state==DONE.
//  FSM (IDLE, REQ, WAIT, DONE):
//   - IDLE: data_req=0. A capture with ex_mem_en=1 -> REQ; otherwise stay IDLE.
//   - REQ: data_req=1; fields are driven from the latched copy and stay stable.
//     data_addr_ok -> WAIT. data_data_ok arriving in REQ is ignored; the bus guarantees >=1 cycle gap.
//   - WAIT: data_req=0. When data_data_ok arrives:
//     - rdata_buf <= data_rdata.
//     - If the entry leaves (downstream allow): a new capture goes to REQ or IDLE per the new ex_mem_en; no capture -> IDLE.
//     - If downstream stalls: -> DONE.
//   - DONE: mem_rdata=rdata_buf. The entry leaves on mem_wb_reg_allow_in, then the next state follows the WAIT exit rule.
//  Latency:
//   - A non-memory op is presented one cycle after capture.
//   - A load/store takes capture + 1 (REQ) + addr_ok wait + data_ok wait.
//   - Back-to-back memory ops: the next REQ starts the cycle after data_ok. No bubble is added beyond that.
//  Boundaries:
//   - Downstream stall with a memory op pending: the FSM still completes the request; it never re-issues.
//   - Exactly one request is issued per captured memory op.
//   - Reset asserted mid-REQ or mid-WAIT returns to IDLE immediately; no response is awaited.
//   - mem_rdata is don't-care for stores and non-memory ops; the bench must not check it.
// STRUCTURE
//  - pipeline.vh: `EX_DATA, state encodings (`MEM_IDLE=2'd0, `MEM_REQ=2'd1, `MEM_WAIT=2'd2, `MEM_DONE=2'd3).
//  - One sub-module is natural: data_req_fsm. It owns the state, data_req and rdata_buf, and outputs mem_done.
//    ex_mem_reg keeps the valid/allow_in handshake and the data latches.
// TESTING
//  1. Reset low mid-WAIT -> next edge: state IDLE, data_req=0, mem_to_wb_reg_valid=0.
//  2. ALU op, ex_data=0x5A, downstream ready -> mem_to_wb_reg_valid=1 one cycle later with data 0x5A, data_req never 1.
//  3. Load addr 0x100, addr_ok after 2 cycles, data_ok 1 cycle later with rdata 0xDEADBEEF ->
//     data_req high exactly 3 cycles; mem_to_wb_reg_valid=1 in the data_ok cycle with mem_rdata 0xDEADBEEF.
//  4. Load completes while mem_wb_reg_allow_in=0 for 4 cycles -> state DONE; mem_rdata stays 0xDEADBEEF;
//     allow_in=0; no second data_req.
//  5. Store (wstrb 4'b0011) then load back-to-back ->
//     second data_req rises the cycle after the store data_ok; data_wr/addr/wstrb stable while data_req=1.
//  6. Random addr_ok/data_ok delays 0-5 and random downstream stall, 1000 ops ->
//     in-order retirement, one request per memory op, no dropped or duplicated entries.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg
//   Shared definitions for the EX->MEM pipeline register: EX bundle width,
//   default memory bus widths and the data-memory request state type.
//   Ports: none (package).
package ex_mem_reg_pkg;

  localparam int unsigned EX_DATA_W  = 64;
  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  // State entered when the stage slot is (re)filled: a memory op needs a
  // request, anything else (or an empty slot) sits in IDLE.
  function automatic mem_state_e next_entry_state(input logic capture,
                                                  input logic mem_en);
    return (capture && mem_en) ? MEM_REQ : MEM_IDLE;
  endfunction

endpackage

// File: rtl/ex_mem_reg_data_req_fsm.sv
// data_req_fsm
//   Data-memory request sequencer for the EX->MEM stage. Issues exactly one
//   request per captured memory op, waits for the response and buffers load
//   data if the downstream stage is stalled when the response arrives.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset
//     capture           stage captures a new instruction this cycle
//     cap_mem_en        the instruction being captured accesses memory
//     leave             current entry moves downstream this cycle
//     data_addr_ok      request accepted by the bus
//     data_data_ok      response (read data / write ack) this cycle
//     data_rdata        read data, valid with data_data_ok
//     data_req          memory request (registered)
//     mem_done          memory access of the current entry has completed
//     mem_rdata         load data: live bus data in the response cycle,
//                       buffered copy afterwards
module data_req_fsm
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              cap_mem_en,
  input  logic              leave,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              data_req,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata
);

  mem_state_e        state;
  mem_state_e        entry_state;
  logic [DATA_W-1:0] rdata_buf;

  assign entry_state = next_entry_state(capture, cap_mem_en);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= MEM_IDLE;
      data_req  <= 1'b0;
      rdata_buf <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          state    <= entry_state;
          data_req <= (entry_state == MEM_REQ);
        end
        MEM_REQ: begin
          // data_data_ok cannot arrive here: the bus leaves a gap after addr_ok.
          if (data_addr_ok) begin
            state    <= MEM_WAIT;
            data_req <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (data_data_ok) begin
            rdata_buf <= data_rdata;
            if (leave) begin
              state    <= entry_state;
              data_req <= (entry_state == MEM_REQ);
            end else begin
              state <= MEM_DONE;
            end
          end
        end
        MEM_DONE: begin
          if (leave) begin
            state    <= entry_state;
            data_req <= (entry_state == MEM_REQ);
          end
        end
        default: begin
          state    <= MEM_IDLE;
          data_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_done  = ((state == MEM_WAIT) && data_data_ok) || (state == MEM_DONE);
  // Only DONE needs the buffer; in the response cycle the bus data is forwarded.
  assign mem_rdata = (state == MEM_DONE) ? rdata_buf : data_rdata;

endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg
//   EX->MEM pipeline register. Latches the EX result bundle and memory access
//   fields, runs the valid/allow_in handshake and holds the entry until any
//   load/store has completed on the data-memory bus.
//   Ports:
//     clk, reset                 clock, asynchronous active-low reset
//     ex_to_mem_reg_valid        upstream holds a valid instruction
//     ex_mem_reg_allow_in        this stage can accept this cycle
//     ex_data                    EX result bundle
//     ex_mem_en/wr/addr/wdata/wstrb  memory access fields from EX
//     mem_wb_reg_allow_in        downstream can accept
//     mem_to_wb_reg_valid        valid and ready_go toward mem_wb_reg
//     ex_mem_reg_data            latched EX bundle
//     mem_rdata                  load data for the current entry
//     data_req/wr/addr/wdata/wstrb   data-memory request, fields from latches
//     data_addr_ok/data_data_ok/data_rdata  data-memory bus responses
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned EX_W   = EX_DATA_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_to_mem_reg_valid,
  output logic                ex_mem_reg_allow_in,
  input  logic [EX_W-1:0]     ex_data,
  input  logic                ex_mem_en,
  input  logic                ex_mem_wr,
  input  logic [ADDR_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_mem_wdata,
  input  logic [DATA_W/8-1:0] ex_mem_wstrb,
  input  logic                mem_wb_reg_allow_in,
  output logic                mem_to_wb_reg_valid,
  output logic [EX_W-1:0]     ex_mem_reg_data,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                data_req,
  output logic                data_wr,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W/8-1:0] data_wstrb,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  logic                valid;
  logic                mem_en_q;
  logic                mem_done;
  logic                ready_go;
  logic                capture;
  logic                leave;
  logic [EX_W-1:0]     data_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  assign ready_go            = !mem_en_q || mem_done;
  assign ex_mem_reg_allow_in = !valid || (ready_go && mem_wb_reg_allow_in);
  assign capture             = ex_mem_reg_allow_in && ex_to_mem_reg_valid;
  assign leave               = valid && ready_go && mem_wb_reg_allow_in;
  assign mem_to_wb_reg_valid = valid && ready_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      data_q   <= '0;
      mem_en_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      // allow_in with no new instruction empties the slot (the entry left).
      if (ex_mem_reg_allow_in) begin
        valid <= ex_to_mem_reg_valid;
      end
      if (capture) begin
        data_q   <= ex_data;
        mem_en_q <= ex_mem_en;
        wr_q     <= ex_mem_wr;
        addr_q   <= ex_mem_addr;
        wdata_q  <= ex_mem_wdata;
        wstrb_q  <= ex_mem_wstrb;
      end
    end
  end

  data_req_fsm #(
    .DATA_W (DATA_W)
  ) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .cap_mem_en   (ex_mem_en),
    .leave        (leave),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .data_req     (data_req),
    .mem_done     (mem_done),
    .mem_rdata    (mem_rdata)
  );

  assign ex_mem_reg_data = data_q;
  assign data_wr         = wr_q;
  assign data_addr       = addr_q;
  assign data_wdata      = wdata_q;
  assign data_wstrb      = wstrb_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg
//   Directed and randomised checks of the EX->MEM pipeline register: reset,
//   ALU pass-through, load/store request sequencing, downstream stall with
//   buffered load data, back-to-back memory ops and a 1000-op random run
//   against an in-order scoreboard and a simple bus responder.
`define CHK(tag, obs, exp) begin n_assert++; if (64'(obs) !== 64'(exp)) begin n_fail++; $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, 64'(obs), 64'(exp)); end end

module tb_ex_mem_reg;
  import ex_mem_reg_pkg::*;

  localparam int unsigned EX_W   = EX_DATA_W;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_OPS  = 1000;

  logic                clk = 1'b0;
  logic                reset;
  logic                ex_to_mem_reg_valid;
  logic                ex_mem_reg_allow_in;
  logic [EX_W-1:0]     ex_data;
  logic                ex_mem_en;
  logic                ex_mem_wr;
  logic [ADDR_W-1:0]   ex_mem_addr;
  logic [DATA_W-1:0]   ex_mem_wdata;
  logic [DATA_W/8-1:0] ex_mem_wstrb;
  logic                mem_wb_reg_allow_in;
  logic                mem_to_wb_reg_valid;
  logic [EX_W-1:0]     ex_mem_reg_data;
  logic [DATA_W-1:0]   mem_rdata;
  logic                data_req;
  logic                data_wr;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic [DATA_W/8-1:0] data_wstrb;
  logic                data_addr_ok;
  logic                data_data_ok;
  logic [DATA_W-1:0]   data_rdata;

  always #5 clk = ~clk;

  ex_mem_reg #(
    .EX_W   (EX_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .ex_to_mem_reg_valid (ex_to_mem_reg_valid),
    .ex_mem_reg_allow_in (ex_mem_reg_allow_in),
    .ex_data             (ex_data),
    .ex_mem_en           (ex_mem_en),
    .ex_mem_wr           (ex_mem_wr),
    .ex_mem_addr         (ex_mem_addr),
    .ex_mem_wdata        (ex_mem_wdata),
    .ex_mem_wstrb        (ex_mem_wstrb),
    .mem_wb_reg_allow_in (mem_wb_reg_allow_in),
    .mem_to_wb_reg_valid (mem_to_wb_reg_valid),
    .ex_mem_reg_data     (ex_mem_reg_data),
    .mem_rdata           (mem_rdata),
    .data_req            (data_req),
    .data_wr             (data_wr),
    .data_addr           (data_addr),
    .data_wdata          (data_wdata),
    .data_wstrb          (data_wstrb),
    .data_addr_ok        (data_addr_ok),
    .data_data_ok        (data_data_ok),
    .data_rdata          (data_rdata)
  );

  typedef struct packed {
    logic [EX_W-1:0]   data;
    logic              mem_en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
  } op_t;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  op_t         q[$];
  op_t         src;
  bit          src_valid;
  int          issued, retired, req_cnt, mem_ret, cyc, ph, hi;
  int unsigned aw, dw;

  initial begin
    reset               = 1'b0;
    ex_to_mem_reg_valid = 1'b0;
    ex_data             = '0;
    ex_mem_en           = 1'b0;
    ex_mem_wr           = 1'b0;
    ex_mem_addr         = '0;
    ex_mem_wdata        = '0;
    ex_mem_wstrb        = '0;
    mem_wb_reg_allow_in = 1'b1;
    data_addr_ok        = 1'b0;
    data_data_ok        = 1'b0;
    data_rdata          = '0;
    aw = 0; dw = 0;

    tick();
    `CHK("rst_allow_in", ex_mem_reg_allow_in, 1);
    `CHK("rst_valid",    mem_to_wb_reg_valid, 0);
    `CHK("rst_req",      data_req, 0);
    `CHK("rst_data",     ex_mem_reg_data, 0);
    `CHK("rst_addr",     data_addr, 0);
    `CHK("rst_wstrb",    data_wstrb, 0);
    `CHK("rst_state",    dut.u_fsm.state, MEM_IDLE);
    reset = 1'b1;
    tick();

    ex_to_mem_reg_valid = 1'b1; ex_mem_en = 1'b1; ex_mem_wr = 1'b0;
    ex_mem_addr = 32'h40; ex_data = 64'h11;
    mid();
    `CHK("t1_allow_in", ex_mem_reg_allow_in, 1);
    tick();
    ex_to_mem_reg_valid = 1'b0; ex_mem_en = 1'b0; data_addr_ok = 1'b1;
    mid();
    `CHK("t1_req", data_req, 1);
    tick();
    data_addr_ok = 1'b0;
    mid();
    `CHK("t1_wait", dut.u_fsm.state, MEM_WAIT);
    reset = 1'b0;
    #1;
    `CHK("t1_async_state", dut.u_fsm.state, MEM_IDLE);
    tick();
    `CHK("t1_state", dut.u_fsm.state, MEM_IDLE);
    `CHK("t1_req_low", data_req, 0);
    `CHK("t1_valid", mem_to_wb_reg_valid, 0);
    reset = 1'b1;
    tick();

    ex_to_mem_reg_valid = 1'b1; ex_mem_en = 1'b0; ex_data = 64'h5A;
    mid();
    `CHK("t2_req_cap", data_req, 0);
    tick();
    ex_to_mem_reg_valid = 1'b0;
    mid();
    `CHK("t2_valid", mem_to_wb_reg_valid, 1);
    `CHK("t2_data",  ex_mem_reg_data, 64'h5A);
    `CHK("t2_req",   data_req, 0);
    tick();
    mid();
    `CHK("t2_gone", mem_to_wb_reg_valid, 0);
    `CHK("t2_req_after", data_req, 0);
    tick();

    hi = 0;
    ex_to_mem_reg_valid = 1'b1; ex_mem_en = 1'b1; ex_mem_wr = 1'b0;
    ex_mem_addr = 32'h100; ex_data = 64'h77;
    mid(); if (data_req) hi++;
    tick();
    ex_to_mem_reg_valid = 1'b0; ex_mem_en = 1'b0;
    mid(); if (data_req) hi++;
    `CHK("t3_addr", data_addr, 32'h100);
    `CHK("t3_wr",   data_wr, 0);
    `CHK("t3_hold", mem_to_wb_reg_valid, 0);
    tick();
    mid(); if (data_req) hi++;
    tick();
    data_addr_ok = 1'b1;
    mid(); if (data_req) hi++;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    mid(); if (data_req) hi++;
    `CHK("t3_valid", mem_to_wb_reg_valid, 1);
    `CHK("t3_rdata", mem_rdata, 32'hDEADBEEF);
    `CHK("t3_data",  ex_mem_reg_data, 64'h77);
    tick();
    data_data_ok = 1'b0; data_rdata = '0;
    mid(); if (data_req) hi++;
    `CHK("t3_gone",  mem_to_wb_reg_valid, 0);
    `CHK("t3_state", dut.u_fsm.state, MEM_IDLE);
    `CHK("t3_req_cycles", hi, 3);
    tick();

    mem_wb_reg_allow_in = 1'b0;
    ex_to_mem_reg_valid = 1'b1; ex_mem_en = 1'b1; ex_mem_wr = 1'b0;
    ex_mem_addr = 32'h200; ex_data = 64'h88;
    mid();
    tick();
    ex_to_mem_reg_valid = 1'b0; ex_mem_en = 1'b0; data_addr_ok = 1'b1;
    mid();
    `CHK("t4_req", data_req, 1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    mid();
    `CHK("t4_valid_ok", mem_to_wb_reg_valid, 1);
    `CHK("t4_allow_ok", ex_mem_reg_allow_in, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      data_data_ok = 1'b0; data_rdata = 32'h12345678;
      mid();
      n_assert++;
      if (dut.u_fsm.state !== MEM_DONE) begin
        n_fail++; $error("FAIL t4_state: %0d", dut.u_fsm.state);
      end
      n_assert++;
      if (mem_rdata !== 32'hDEADBEEF) begin
        n_fail++; $error("FAIL t4_rdata: 0x%0h", mem_rdata);
      end
      n_assert++;
      if (ex_mem_reg_allow_in !== 1'b0) begin
        n_fail++; $error("FAIL t4_allow");
      end
      n_assert++;
      if (data_req !== 1'b0) begin
        n_fail++; $error("FAIL t4_noreq");
      end
      `CHK("t4_valid", mem_to_wb_reg_valid, 1);
      tick();
    end
    mem_wb_reg_allow_in = 1'b1;
    mid();
    `CHK("t4_release_allow", ex_mem_reg_allow_in, 1);
    `CHK("t4_release_rdata", mem_rdata, 32'hDEADBEEF);
    tick();
    mid();
    `CHK("t4_idle", dut.u_fsm.state, MEM_IDLE);
    `CHK("t4_gone", mem_to_wb_reg_valid, 0);
    `CHK("t4_noreq_end", data_req, 0);
    tick();

    ex_to_mem_reg_valid = 1'b1; ex_mem_en = 1'b1; ex_mem_wr = 1'b1;
    ex_mem_addr = 32'h300; ex_mem_wdata = 32'hCAFEF00D; ex_mem_wstrb = 4'b0011;
    ex_data = 64'h31;
    mid();
    tick();
    ex_mem_wr = 1'b0; ex_mem_addr = 32'h304; ex_mem_wdata = 32'h0; ex_mem_wstrb = 4'b0000;
    ex_data = 64'h32;
    mid();
    `CHK("t5_req1",   data_req, 1);
    `CHK("t5_wr1",    data_wr, 1);
    `CHK("t5_addr1",  data_addr, 32'h300);
    `CHK("t5_wstrb1", data_wstrb, 4'b0011);
    `CHK("t5_wdata1", data_wdata, 32'hCAFEF00D);
    `CHK("t5_block",  ex_mem_reg_allow_in, 0);
    tick();
    data_addr_ok = 1'b1;
    mid();
    `CHK("t5_req1b",   data_req, 1);
    `CHK("t5_wr1b",    data_wr, 1);
    `CHK("t5_addr1b",  data_addr, 32'h300);
    `CHK("t5_wstrb1b", data_wstrb, 4'b0011);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    mid();
    `CHK("t5_req_gap",  data_req, 0);
    `CHK("t5_st_valid", mem_to_wb_reg_valid, 1);
    `CHK("t5_st_data",  ex_mem_reg_data, 64'h31);
    `CHK("t5_allow",    ex_mem_reg_allow_in, 1);
    tick();
    ex_to_mem_reg_valid = 1'b0; data_data_ok = 1'b0; data_addr_ok = 1'b1;
    mid();
    `CHK("t5_req2",   data_req, 1);
    `CHK("t5_wr2",    data_wr, 0);
    `CHK("t5_addr2",  data_addr, 32'h304);
    `CHK("t5_ld_data", ex_mem_reg_data, 64'h32);
    `CHK("t5_ld_hold", mem_to_wb_reg_valid, 0);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000A5A5;
    mid();
    `CHK("t5_ld_valid", mem_to_wb_reg_valid, 1);
    `CHK("t5_ld_rdata", mem_rdata, 32'h0000A5A5);
    tick();
    data_data_ok = 1'b0;
    mid();
    `CHK("t5_end_req", data_req, 0);
    `CHK("t5_end_valid", mem_to_wb_reg_valid, 0);
    tick();

    issued = 0; retired = 0; req_cnt = 0; mem_ret = 0; cyc = 0; ph = 0;
    src_valid = 1'b0; src = '0;
    while (retired < N_OPS && cyc < 60000) begin
      cyc++;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
      if (data_req) begin
        if (ph != 1) begin
          req_cnt++;
          aw = $urandom_range(0, 5);
          ph = 1;
        end
        if (aw == 0) begin
          data_addr_ok = 1'b1;
          ph = 2;
          dw = $urandom_range(0, 5);
          if (q.size() > 0) begin
            `CHK("t6_addr", data_addr, q[0].addr);
            `CHK("t6_wr",   data_wr, q[0].wr);
          end
        end else begin
          aw--;
        end
      end else if (ph == 2) begin
        if (dw == 0) begin
          data_data_ok = 1'b1;
          if (q.size() > 0) data_rdata = rd_model(q[0].addr);
          ph = 0;
        end else begin
          dw--;
        end
      end
      mem_wb_reg_allow_in = ($urandom_range(0, 3) != 0);
      if (!src_valid && issued < N_OPS && $urandom_range(0, 3) != 0) begin
        src.data   = {32'(issued), 32'($urandom)};
        src.mem_en = 1'($urandom_range(0, 1));
        src.wr     = 1'($urandom_range(0, 1));
        src.addr   = $urandom & 32'hFFFF_FFFC;
        src_valid  = 1'b1;
        issued++;
      end
      ex_to_mem_reg_valid = src_valid;
      ex_data             = src.data;
      ex_mem_en           = src.mem_en;
      ex_mem_wr           = src.wr;
      ex_mem_addr         = src.addr;
      ex_mem_wdata        = $urandom;
      ex_mem_wstrb        = 4'hF;
      mid();
      if (mem_to_wb_reg_valid && mem_wb_reg_allow_in) begin
        if (q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL t6_retire_occupancy: retirement with empty scoreboard");
        end else begin
          n_assert++;
          if (ex_mem_reg_data !== q[0].data) begin
            n_fail++;
            $error("FAIL t6_order: observed 0x%0h expected 0x%0h", ex_mem_reg_data, q[0].data);
          end
          if (q[0].mem_en && !q[0].wr) begin
            n_assert++;
            if (mem_rdata !== rd_model(q[0].addr)) begin
              n_fail++;
              $error("FAIL t6_rdata: observed 0x%0h expected 0x%0h", mem_rdata, rd_model(q[0].addr));
            end
          end
          if (q[0].mem_en) begin
            mem_ret++;
            n_assert++;
            if (req_cnt != mem_ret) begin
              n_fail++;
              $error("FAIL t6_req_count: observed %0d expected %0d", req_cnt, mem_ret);
            end
          end
          void'(q.pop_front());
          retired++;
        end
      end
      if (ex_to_mem_reg_valid && ex_mem_reg_allow_in) begin
        q.push_back(src);
        src_valid = 1'b0;
      end
      tick();
    end
    n_assert++;
    if (retired != N_OPS) begin
      n_fail++; $error("FAIL t6_retired: %0d", retired);
    end
    n_assert++;
    if (req_cnt != mem_ret) begin
      n_fail++; $error("FAIL t6_total_req: %0d vs %0d", req_cnt, mem_ret);
    end
    n_assert++;
    if (q.size() != 0) begin
      n_fail++; $error("FAIL t6_drained: %0d", q.size());
    end

    ex_to_mem_reg_valid = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
